rf_wb_arbiter: RTL and testbench

Write-port arbiter for the 8-entry × 8-bit register file, which has a single write port. It sits between the two writeback sources (single-cycle ALU results and variable-latency load results from data memory) and the register file's `regWrite`/`Rd`/`writeValue` inputs. Load results that lose arbitration are held in a small in-order queue. The block also reports pending-write hazards to the issue stage.

---
 rtl/rf_pkg.sv | 14 +
 rtl/rf_wb_arbiter_if.sv | 32 +++
 rtl/rf_wb_fifo.sv | 79 +++++++
 rtl/rf_wb_arbiter.sv | 91 +++++++++
 tb/tb_rf_wb_arbiter.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared register-file constants and the writeback queue entry type.
package rf_pkg;

    localparam int REG_W    = 8;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [REG_W-1:0]  val;
        logic              live;
    } wb_entry_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback arbiter bus: ALU/load sources, hazard query and register-file write port.
interface rf_wb_arbiter_if #(
    parameter int DEPTH = 2
);

    logic                        aluWrite;
    logic [rf_pkg::ADDR_W-1:0]   aluRd;
    logic [rf_pkg::REG_W-1:0]    aluValue;
    logic                        ldValid;
    logic [rf_pkg::ADDR_W-1:0]   ldRd;
    logic [rf_pkg::REG_W-1:0]    ldValue;
    logic                        ldReady;
    logic [rf_pkg::ADDR_W-1:0]   qRs;
    logic [rf_pkg::ADDR_W-1:0]   qRd;
    logic                        hazRs;
    logic                        hazRd;
    logic                        regWrite;
    logic [rf_pkg::ADDR_W-1:0]   Rd;
    logic [rf_pkg::REG_W-1:0]    writeValue;
    logic [$clog2(DEPTH+1)-1:0]  occupancy;

    modport master (
        output aluWrite, aluRd, aluValue, ldValid, ldRd, ldValue, qRs, qRd,
        input  ldReady, hazRs, hazRd, regWrite, Rd, writeValue, occupancy
    );

    modport slave (
        input  aluWrite, aluRd, aluValue, ldValid, ldRd, ldValue, qRs, qRd,
        output ldReady, hazRs, hazRd, regWrite, Rd, writeValue, occupancy
    );

endinterface

// File: rtl/rf_wb_fifo.sv
// In-order load writeback queue with per-entry WAW squash and hazard lookup.
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic                       push,
    input  wb_entry_t                  push_entry,
    input  logic                       pop,
    input  logic                       squash_en,
    input  logic [ADDR_W-1:0]          squash_rd,
    input  logic [ADDR_W-1:0]          q_rs,
    input  logic [ADDR_W-1:0]          q_rd,
    output wb_entry_t                  head,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       haz_rs,
    output logic                       haz_rd
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] rd_mem  [DEPTH];
    logic [REG_W-1:0]  val_mem [DEPTH];
    logic [DEPTH-1:0]  live_q;
    logic [PTR_W-1:0]  head_ptr;
    logic [PTR_W-1:0]  tail_ptr;

    // Live bits are cleared on pop, so a set live bit always marks a stored entry.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            live_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash_en && rd_mem[i] == squash_rd) begin
                    live_q[i] <= 1'b0;
                end
            end
            if (pop) begin
                live_q[head_ptr] <= 1'b0;
                head_ptr         <= head_ptr + PTR_W'(1);
            end
            if (push) begin
                live_q[tail_ptr] <= push_entry.live;
                tail_ptr         <= tail_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            rd_mem[tail_ptr]  <= push_entry.rd;
            val_mem[tail_ptr] <= push_entry.val;
        end
    end

    assign head  = '{rd: rd_mem[head_ptr], val: val_mem[head_ptr], live: live_q[head_ptr]};
    assign empty = (count == '0);

    always_comb begin
        haz_rs = 1'b0;
        haz_rd = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && rd_mem[i] == q_rs) haz_rs = 1'b1;
            if (live_q[i] && rd_mem[i] == q_rd) haz_rd = 1'b1;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Single write-port arbiter: ALU first, then queued loads in order, else load bypass.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic           CLK,
    input  logic           Reset,
    rf_wb_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    wb_entry_t         head;
    wb_entry_t         push_entry;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              ld_ready;
    logic              xfer;
    logic              bypass;
    logic              push;
    logic              pop;
    logic              wr;
    logic [ADDR_W-1:0] wr_rd;
    logic [REG_W-1:0]  wr_val;
    logic              haz_rs;
    logic              haz_rd;

    assign ld_ready = !Reset && (count < DEPTH_C);
    assign xfer     = bus.ldValid && ld_ready;
    assign bypass   = !bus.aluWrite && empty && xfer;
    assign push     = xfer && !bypass;

    // A load colliding with a same-cycle ALU write to the same register is older, so it is born dead.
    assign push_entry = '{rd:   bus.ldRd,
                          val:  bus.ldValue,
                          live: !(bus.aluWrite && bus.aluRd == bus.ldRd)};

    always_comb begin
        wr     = 1'b0;
        wr_rd  = '0;
        wr_val = '0;
        pop    = 1'b0;
        if (!Reset) begin
            if (bus.aluWrite) begin
                wr     = 1'b1;
                wr_rd  = bus.aluRd;
                wr_val = bus.aluValue;
                pop    = !empty && !head.live;
            end else if (!empty) begin
                pop = 1'b1;
                if (head.live) begin
                    wr     = 1'b1;
                    wr_rd  = head.rd;
                    wr_val = head.val;
                end
            end else if (xfer) begin
                wr     = 1'b1;
                wr_rd  = bus.ldRd;
                wr_val = bus.ldValue;
            end
        end
    end

    rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK        (CLK),
        .Reset      (Reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .squash_en  (bus.aluWrite && !Reset),
        .squash_rd  (bus.aluRd),
        .q_rs       (bus.qRs),
        .q_rd       (bus.qRd),
        .head       (head),
        .empty      (empty),
        .count      (count),
        .haz_rs     (haz_rs),
        .haz_rd     (haz_rd)
    );

    assign bus.ldReady    = ld_ready;
    assign bus.regWrite   = wr;
    assign bus.Rd         = wr_rd;
    assign bus.writeValue = wr_val;
    assign bus.hazRs      = !Reset && haz_rs;
    assign bus.hazRd      = !Reset && haz_rd;
    assign bus.occupancy  = count;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, hand sequences, random vs queue model.
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    localparam int DEPTH = 2;

    logic CLK = 1'b0;
    logic Reset;
    always #5 CLK = ~CLK;

    rf_wb_arbiter_if #(.DEPTH(DEPTH)) bus ();

    rf_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        alu;
        logic [2:0]  a_rd;
        logic [7:0]  a_val;
        logic        ldv;
        logic [2:0]  l_rd;
        logic [7:0]  l_val;
        logic [2:0]  q_rs;
        logic [2:0]  q_rd;
        logic [16:0] exp;   // {ldReady, regWrite, Rd, writeValue, hazRs, hazRd, occupancy}
    } vec_t;

    typedef struct {
        logic [2:0] rd;
        logic [7:0] val;
        bit         live;
    } ment_t;

    int    total = 0;
    int    bad   = 0;
    vec_t  tbl[$];
    ment_t mq[$];

    function automatic vec_t mk(string n, bit rst, bit alu, int ar, int av, bit ldv, int lr, int lv,
                                int qs, int qd, bit rdy, bit wr, int rd, int v, bit hs, bit hd, int occ);
        vec_t t;
        t.name = n;  t.rst = rst;  t.alu = alu;  t.a_rd = 3'(ar);  t.a_val = 8'(av);
        t.ldv = ldv; t.l_rd = 3'(lr); t.l_val = 8'(lv); t.q_rs = 3'(qs); t.q_rd = 3'(qd);
        t.exp = {rdy, wr, 3'(rd), 8'(v), hs, hd, 2'(occ)};
        return t;
    endfunction

    task automatic apply(input vec_t v);
        logic [16:0] obs;
        Reset        = v.rst;
        bus.aluWrite = v.alu;  bus.aluRd = v.a_rd;  bus.aluValue = v.a_val;
        bus.ldValid  = v.ldv;  bus.ldRd  = v.l_rd;  bus.ldValue  = v.l_val;
        bus.qRs      = v.q_rs; bus.qRd   = v.q_rd;
        #4;
        obs = {bus.ldReady, bus.regWrite, bus.Rd, bus.writeValue, bus.hazRs, bus.hazRd, bus.occupancy};
        total++;
        if (obs !== v.exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (rdy,wr,rd,val,hrs,hrd,occ)", v.name, obs, v.exp);
        end
        @(posedge CLK);
        #1;
    endtask

    // Reference: predicts this cycle's outputs from the queue, then advances the queue past the edge.
    task automatic model(inout vec_t v);
        bit         rdy;
        bit         hs;
        bit         hd;
        bit         wr;
        bit         xfer;
        bit         byp;
        logic [2:0] rd;
        logic [7:0] val;
        int         occ;
        rdy = !v.rst && (mq.size() < DEPTH);
        hs = 0; hd = 0; wr = 0; byp = 0; rd = 0; val = 0;
        occ  = mq.size();
        xfer = v.ldv && rdy;
        if (!v.rst) begin
            foreach (mq[i]) begin
                if (mq[i].live && mq[i].rd == v.q_rs) hs = 1;
                if (mq[i].live && mq[i].rd == v.q_rd) hd = 1;
            end
        end
        if (v.rst) begin
            mq.delete();
        end else begin
            if (v.alu) begin
                wr = 1; rd = v.a_rd; val = v.a_val;
                if (mq.size() > 0 && !mq[0].live) void'(mq.pop_front());
            end else if (mq.size() > 0) begin
                if (mq[0].live) begin
                    wr = 1; rd = mq[0].rd; val = mq[0].val;
                end
                void'(mq.pop_front());
            end else if (xfer) begin
                byp = 1; wr = 1; rd = v.l_rd; val = v.l_val;
            end
            if (v.alu) begin
                foreach (mq[i]) if (mq[i].rd == v.a_rd) mq[i].live = 0;
            end
            if (xfer && !byp) mq.push_back('{v.l_rd, v.l_val, !(v.alu && v.a_rd == v.l_rd)});
        end
        v.exp = {rdy, wr, rd, val, hs, hd, 2'(occ)};
    endtask

    initial begin
        Reset = 1'b1;
        bus.aluWrite = 0; bus.aluRd = 0; bus.aluValue = 0;
        bus.ldValid = 0;  bus.ldRd = 0;  bus.ldValue = 0;
        bus.qRs = 0;      bus.qRd = 0;
        repeat (2) @(posedge CLK);
        #1;

        //                 name        rst alu ar av    ldv lr lv    qs qd  rdy wr rd v     hs hd occ
        tbl.push_back(mk("reset",      1,  0,  0, 0,    0,  0, 0,    0, 0,  0,  0, 0, 0,    0, 0, 0));
        tbl.push_back(mk("idle",       0,  0,  0, 0,    0,  0, 0,    0, 0,  1,  0, 0, 0,    0, 0, 0));
        tbl.push_back(mk("bypass",     0,  0,  0, 0,    1,  3, 'h5A, 0, 0,  1,  1, 3, 'h5A, 0, 0, 0));
        tbl.push_back(mk("post_byp",   0,  0,  0, 0,    0,  0, 0,    0, 0,  1,  0, 0, 0,    0, 0, 0));
        tbl.push_back(mk("conflict",   0,  1,  1, 'h11, 1,  2, 'h22, 2, 0,  1,  1, 1, 'h11, 0, 0, 0));
        tbl.push_back(mk("drain_ld",   0,  0,  0, 0,    0,  0, 0,    2, 0,  1,  1, 2, 'h22, 1, 0, 1));
        tbl.push_back(mk("drained",    0,  0,  0, 0,    0,  0, 0,    2, 0,  1,  0, 0, 0,    0, 0, 0));
        tbl.push_back(mk("sq_queue",   0,  1,  5, 'h55, 1,  4, 'h44, 0, 4,  1,  1, 5, 'h55, 0, 0, 0));
        tbl.push_back(mk("sq_alu",     0,  1,  4, 'h99, 0,  0, 0,    0, 4,  1,  1, 4, 'h99, 0, 1, 1));
        tbl.push_back(mk("sq_deadpop", 0,  0,  0, 0,    0,  0, 0,    0, 4,  1,  0, 0, 0,    0, 0, 1));
        tbl.push_back(mk("sq_empty",   0,  0,  0, 0,    0,  0, 0,    0, 4,  1,  0, 0, 0,    0, 0, 0));
        tbl.push_back(mk("samerd",     0,  1,  6, 'h66, 1,  6, 'h77, 6, 0,  1,  1, 6, 'h66, 0, 0, 0));
        tbl.push_back(mk("samerd_pop", 0,  0,  0, 0,    0,  0, 0,    6, 0,  1,  0, 0, 0,    0, 0, 1));
        tbl.push_back(mk("samerd_end", 0,  0,  0, 0,    0,  0, 0,    6, 0,  1,  0, 0, 0,    0, 0, 0));
        foreach (tbl[i]) apply(tbl[i]);

        // Full queue: third load is refused until a slot frees, with no pop-through.
        apply(mk("full_c0",  0, 1, 7, 'hA0, 1, 1, 'hB1, 1, 3,  1, 1, 7, 'hA0, 0, 0, 0));
        apply(mk("full_c1",  0, 1, 7, 'hA1, 1, 2, 'hB2, 1, 3,  1, 1, 7, 'hA1, 1, 0, 1));
        apply(mk("full_c2",  0, 1, 7, 'hA2, 1, 3, 'hB3, 1, 3,  0, 1, 7, 'hA2, 1, 0, 2));
        apply(mk("full_c3",  0, 0, 0, 0,    1, 3, 'hB3, 1, 3,  0, 1, 1, 'hB1, 1, 0, 2));
        apply(mk("full_c4",  0, 0, 0, 0,    1, 3, 'hB3, 1, 3,  1, 1, 2, 'hB2, 0, 0, 1));
        apply(mk("full_c5",  0, 0, 0, 0,    0, 0, 0,    1, 3,  1, 1, 3, 'hB3, 0, 1, 1));
        apply(mk("full_c6",  0, 0, 0, 0,    0, 0, 0,    1, 3,  1, 0, 0, 0,    0, 0, 0));

        // Reset with two live entries queued discards them.
        apply(mk("rst_d0",   0, 1, 7, 'hC0, 1, 4, 'hD4, 4, 5,  1, 1, 7, 'hC0, 0, 0, 0));
        apply(mk("rst_d1",   0, 1, 7, 'hC1, 1, 5, 'hD5, 4, 5,  1, 1, 7, 'hC1, 1, 0, 1));
        apply(mk("rst_d2",   1, 0, 0, 0,    0, 0, 0,    4, 5,  0, 0, 0, 0,    0, 0, 2));
        apply(mk("rst_d3",   0, 0, 0, 0,    0, 0, 0,    4, 5,  1, 0, 0, 0,    0, 0, 0));
        apply(mk("rst_d4",   0, 0, 0, 0,    0, 0, 0,    4, 5,  1, 0, 0, 0,    0, 0, 0));

        mq.delete();
        for (int n = 0; n < 1500; n++) begin
            vec_t r;
            r.name  = "random";
            r.rst   = ($urandom_range(0, 63) == 0);
            r.alu   = 1'($urandom_range(0, 1));
            r.a_rd  = 3'($urandom_range(0, 3));
            r.a_val = 8'($urandom);
            r.ldv   = ($urandom_range(0, 3) != 0);
            r.l_rd  = 3'($urandom_range(0, 3));
            r.l_val = 8'($urandom);
            r.q_rs  = 3'($urandom_range(0, 3));
            r.q_rd  = 3'($urandom_range(0, 3));
            model(r);
            apply(r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
